cr_xp10_decomp_be_sched: RTL

Back-end output scheduler for the XP10 decompressor. It merges two sources into the single outbound TLV word stream, in frame order: the passthrough TLV queue (FHP headers and trailers, CRC TLVs) and the LZ decompressed-data queue. It enforces the software output limit on each data TLV. It sits between the back-end FIFOs and the outbound TLV packer.

---
 rtl/cr_xp10_decompPKG.sv | 36 +++
 rtl/cr_xp10_decomp_be_sched.sv | 126 ++++++++++++
 2 files changed

// File: rtl/cr_xp10_decompPKG.sv
// Shared types and constants for the XP10 decompressor back-end output scheduler.
package cr_xp10_decompPKG;

   localparam int unsigned BE_SCHED_DATA_W   = 64;
   localparam int unsigned BE_SCHED_TYP_W    = 8;
   localparam int unsigned BE_SCHED_BYTES_W  = 4;
   localparam int unsigned BE_SCHED_CNT_W    = 25;
   localparam int unsigned BE_SCHED_OLIMIT_W = 24;

   localparam logic [BE_SCHED_TYP_W-1:0] BE_SCHED_DATA_TYP = 8'h05;
   localparam logic [BE_SCHED_TYP_W-1:0] BE_SCHED_FTR_TYP  = 8'h0f;

   typedef struct packed {
      logic [BE_SCHED_DATA_W-1:0] data;
      logic                       sot;
      logic                       eot;
      logic [BE_SCHED_TYP_W-1:0]  typ;
      logic                       err;
   } be_sched_word_t;

   typedef enum logic [1:0] {
      BE_SCHED_ST_PT      = 2'd0,
      BE_SCHED_ST_LZ      = 2'd1,
      BE_SCHED_ST_LZ_DROP = 2'd2
   } be_sched_st_e;

   // Byte count of an LZ word; out-of-range encodings count as a full word.
   function automatic logic [BE_SCHED_BYTES_W-1:0] be_sched_eff_bytes(
      input logic [BE_SCHED_BYTES_W-1:0] b);
      if ((b == '0) || (b > BE_SCHED_BYTES_W'(8)))
         return BE_SCHED_BYTES_W'(8);
      else
         return b;
   endfunction

endpackage

// File: rtl/cr_xp10_decomp_be_sched.sv
// Back-end output scheduler: merges passthrough TLVs and LZ data into one
// outbound word stream in frame order, enforcing the per-TLV output limit.
module cr_xp10_decomp_be_sched
   import cr_xp10_decompPKG::*;
#(
   parameter logic [BE_SCHED_TYP_W-1:0] DATA_TYP = BE_SCHED_DATA_TYP,
   parameter logic [BE_SCHED_TYP_W-1:0] FTR_TYP  = BE_SCHED_FTR_TYP
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          pt_valid,
   input  be_sched_word_t                pt_word,
   output logic                          pt_ready,
   input  logic                          lz_valid,
   input  logic [BE_SCHED_DATA_W-1:0]    lz_data,
   input  logic [BE_SCHED_BYTES_W-1:0]   lz_bytes,
   input  logic                          lz_last,
   output logic                          lz_ready,
   output logic                          ob_valid,
   output be_sched_word_t                ob_word,
   input  logic                          ob_ready,
   input  logic [BE_SCHED_OLIMIT_W-1:0]  sw_LZ_DECOMP_OLIMIT,
   output logic                          err_olimit,
   output logic                          frm_done
);

   localparam int unsigned SUM_W = BE_SCHED_CNT_W + 1;

   be_sched_st_e                state, state_nxt;
   logic [BE_SCHED_CNT_W-1:0]   byte_cnt, byte_cnt_nxt;
   logic                        ob_valid_nxt;
   be_sched_word_t              ob_word_nxt;
   logic                        err_olimit_nxt;
   logic                        frm_done_nxt;

   logic                        ld;
   logic [SUM_W-1:0]            cnt_sum;
   logic [BE_SCHED_CNT_W-1:0]   cnt_sat;
   logic                        ovf;

   assign ld = !ob_valid || ob_ready;

   // Running byte count for the current data TLV, saturating instead of wrapping.
   assign cnt_sum = {1'b0, byte_cnt} + SUM_W'(be_sched_eff_bytes(lz_bytes));
   assign cnt_sat = cnt_sum[SUM_W-1] ? '1 : cnt_sum[BE_SCHED_CNT_W-1:0];
   assign ovf     = (sw_LZ_DECOMP_OLIMIT != '0) &&
                    (cnt_sum > SUM_W'(sw_LZ_DECOMP_OLIMIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= BE_SCHED_ST_PT;
         byte_cnt   <= '0;
         ob_valid   <= 1'b0;
         ob_word    <= '0;
         err_olimit <= 1'b0;
         frm_done   <= 1'b0;
      end else begin
         state      <= state_nxt;
         byte_cnt   <= byte_cnt_nxt;
         ob_valid   <= ob_valid_nxt;
         ob_word    <= ob_word_nxt;
         err_olimit <= err_olimit_nxt;
         frm_done   <= frm_done_nxt;
      end
   end

   // Source selection is purely by state; the inactive source is never looked at.
   always_comb begin
      state_nxt      = state;
      byte_cnt_nxt   = byte_cnt;
      ob_valid_nxt   = ob_valid && !ob_ready;
      ob_word_nxt    = ob_word;
      err_olimit_nxt = 1'b0;
      frm_done_nxt   = 1'b0;
      pt_ready       = 1'b0;
      lz_ready       = 1'b0;

      case (state)
         BE_SCHED_ST_PT: begin
            pt_ready = ld;
            if (pt_valid && ld) begin
               ob_valid_nxt = 1'b1;
               ob_word_nxt  = pt_word;
               frm_done_nxt = pt_word.eot && (pt_word.typ == FTR_TYP);
               if (pt_word.sot && (pt_word.typ == DATA_TYP)) begin
                  state_nxt    = BE_SCHED_ST_LZ;
                  byte_cnt_nxt = '0;
               end
            end
         end

         BE_SCHED_ST_LZ: begin
            lz_ready = ld;
            if (lz_valid && ld) begin
               ob_valid_nxt     = 1'b1;
               ob_word_nxt.data = lz_data;
               ob_word_nxt.sot  = 1'b0;
               ob_word_nxt.eot  = lz_last || ovf;
               ob_word_nxt.typ  = DATA_TYP;
               ob_word_nxt.err  = ovf;
               err_olimit_nxt   = ovf;
               byte_cnt_nxt     = cnt_sat;
               if (ovf)
                  state_nxt = lz_last ? BE_SCHED_ST_PT : BE_SCHED_ST_LZ_DROP;
               else if (lz_last)
                  state_nxt = BE_SCHED_ST_PT;
            end
         end

         BE_SCHED_ST_LZ_DROP: begin
            // Remainder of an over-limit TLV is drained without waiting on the sink.
            lz_ready = 1'b1;
            if (lz_valid && lz_last)
               state_nxt = BE_SCHED_ST_PT;
         end

         default: state_nxt = BE_SCHED_ST_PT;
      endcase

      if (!rst_n) begin
         pt_ready = 1'b0;
         lz_ready = 1'b0;
      end
   end

endmodule
